// File: rtl/oracle_query_seq.sv
// oracle_query_seq: applies one pattern at a time to a combinational core,
// waits a per-query settle time, captures and optionally checks the response.
module oracle_query_seq #(
  parameter int IN_W  = 36,
  parameter int OUT_W = 7,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             q_valid,
  output logic             q_ready,
  input  logic [IN_W-1:0]  q_pattern,
  input  logic [OUT_W-1:0] q_expect,
  input  logic             q_check,
  input  logic [3:0]       settle_cycles,
  output logic [IN_W-1:0]  core_in,
  input  logic [OUT_W-1:0] core_out,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [OUT_W-1:0] r_response,
  output logic             r_mismatch,
  output logic             busy,
  output logic [CNT_W-1:0] query_count,
  output logic [CNT_W-1:0] mismatch_count
);
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  state_t           state;
  logic [3:0]       cnt;
  logic [OUT_W-1:0] exp_q;
  logic             check_q;
  assign q_ready = (state == IDLE) & ~rst;
  assign busy    = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      exp_q          <= '0;
      check_q        <= 1'b0;
      core_in        <= '0;
      r_response     <= '0;
      r_valid        <= 1'b0;
      r_mismatch     <= 1'b0;
      query_count    <= '0;
      mismatch_count <= '0;
    end else if (abort) begin
      state      <= IDLE;
      r_valid    <= 1'b0;
      r_mismatch <= 1'b0;
      core_in    <= '0;
    end else
      case (state)
        IDLE:
          if (q_valid) begin
            core_in <= q_pattern;
            exp_q   <= q_expect;
            check_q <= q_check;
            cnt     <= settle_cycles;
            state   <= SETTLE;
          end
        SETTLE:
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else begin
            r_response <= core_out;
            r_mismatch <= check_q & (core_out != exp_q);
            r_valid    <= 1'b1;
            state      <= RESP;
          end
        RESP:
          if (r_ready) begin
            r_valid     <= 1'b0;
            state       <= IDLE;
            query_count <= &query_count ? query_count : query_count + 1'b1;
            if (r_mismatch && !(&mismatch_count)) mismatch_count <= mismatch_count + 1'b1;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_oracle_query_seq.sv
// tb_oracle_query_seq: randomized transaction-level check of oracle_query_seq
// against a delayed combinational core model and a saturating counter model.
module tb_oracle_query_seq;
  localparam int IN_W = 36, OUT_W = 7, CNT_W = 8;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 1'b0, rst = 1'b1, abort = 1'b0, q_valid = 1'b0, q_check = 1'b0, r_ready = 1'b0;
  logic [IN_W-1:0] q_pattern = '0, core_in;
  logic [OUT_W-1:0] q_expect = '0, core_out, r_response;
  logic [3:0] settle_cycles = '0;
  logic q_ready, r_valid, r_mismatch, busy;
  logic [CNT_W-1:0] query_count, mismatch_count;
  logic [IN_W-1:0] dly [16];
  int tests = 0, fails = 0, core_delay = 0, mq = 0, mm = 0;

  oracle_query_seq #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .abort(abort), .q_valid(q_valid), .q_ready(q_ready),
    .q_pattern(q_pattern), .q_expect(q_expect), .q_check(q_check),
    .settle_cycles(settle_cycles), .core_in(core_in), .core_out(core_out),
    .r_valid(r_valid), .r_ready(r_ready), .r_response(r_response),
    .r_mismatch(r_mismatch), .busy(busy), .query_count(query_count),
    .mismatch_count(mismatch_count));

  always #5 clk = ~clk;

  // Core model: output is a fold of its input, visible core_delay cycles after the input changes.
  function automatic logic [OUT_W-1:0] resp_of(input logic [IN_W-1:0] p);
    logic [OUT_W-1:0] r;
    r = 7'h54;
    for (int i = 0; i < IN_W; i++) r[i % OUT_W] = r[i % OUT_W] ^ p[i];
    return r;
  endfunction

  always @(posedge clk) begin
    dly[0] <= core_in;
    for (int i = 1; i < 16; i++) dly[i] <= dly[i-1];
  end
  always_comb core_out = resp_of(core_delay == 0 ? core_in : dly[core_delay-1]);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bump(input logic mis);
    mq = mq < CMAX ? mq + 1 : mq;
    mm = (mis && mm < CMAX) ? mm + 1 : mm;
  endtask

  task automatic wait_resp(input int s);
    int lat;
    lat = 0;
    do begin
      settle_cycles = 4'($urandom);
      @(negedge clk);
      lat++;
    end while (!r_valid && lat < 40);
    chk("latency", 64'(lat), 64'(s + 1));
  endtask

  // Full query from IDLE: accept, settle, optional back-pressure, handshake.
  task automatic query(input logic [IN_W-1:0] p, input logic [OUT_W-1:0] e, input logic c,
                       input logic [3:0] s, input int hold);
    logic [OUT_W-1:0] er;
    logic em;
    er = resp_of(p);
    em = c && (er != e);
    q_valid = 1'b1; q_pattern = p; q_expect = e; q_check = c; settle_cycles = s; r_ready = 1'b0;
    @(negedge clk);
    chk("accept_core_in", 64'(core_in), 64'(p));
    chk("accept_busy", 64'(busy), 64'(1));
    q_valid = 1'b0; q_pattern = {$urandom, $urandom}; q_expect = 7'($urandom); q_check = 1'($urandom);
    wait_resp(int'(s));
    chk("response", 64'(r_response), 64'(er));
    chk("mismatch", 64'(r_mismatch), 64'(em));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(r_valid), 64'(1));
      chk("hold_response", 64'(r_response), 64'(er));
      chk("hold_mismatch", 64'(r_mismatch), 64'(em));
    end
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    bump(em);
    chk("done_valid", 64'(r_valid), 64'(0));
    chk("done_ready", 64'(q_ready), 64'(1));
    chk("query_count", 64'(query_count), 64'(mq));
    chk("mismatch_count", 64'(mismatch_count), 64'(mm));
    chk("core_in_hold", 64'(core_in), 64'(p));
  endtask

  task automatic chk_aborted(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_ready"}, 64'(q_ready), 64'(1));
    chk({tag, "_core_in"}, 64'(core_in), 64'(0));
    chk({tag, "_valid"}, 64'(r_valid), 64'(0));
    chk({tag, "_mismatch"}, 64'(r_mismatch), 64'(0));
    chk({tag, "_qcount"}, 64'(query_count), 64'(mq));
    chk({tag, "_mcount"}, 64'(mismatch_count), 64'(mm));
  endtask

  initial begin
    int s, seen;
    logic [IN_W-1:0] p;
    #1;
    chk("rst_ready", 64'(q_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_core_in", 64'(core_in), 64'(0));
    chk("rst_valid", 64'(r_valid), 64'(0));
    chk("rst_response", 64'(r_response), 64'(0));
    chk("rst_qcount", 64'(query_count), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_ready", 64'(q_ready), 64'(1));
    @(negedge clk);
    query(36'h0_0000_0001, 7'h00, 1'b0, 4'd0, 0);
    core_delay = 10;
    query(36'h9_ABCD_1234, 7'h00, 1'b0, 4'd15, 0);
    core_delay = 0;
    query(36'h0_0000_0055, 7'h00, 1'b1, 4'd3, 5);
    for (int n = 0; n < 40; n++) begin
      s = $urandom_range(0, 15);
      core_delay = $urandom_range(0, s);
      p = {$urandom, $urandom};
      query(p, $urandom_range(0, 1) ? resp_of(p) : 7'($urandom), 1'($urandom), 4'(s),
            $urandom_range(0, 3));
    end
    core_delay = 0;
    // Abort during SETTLE.
    q_valid = 1'b1; q_pattern = 36'h1_2345_6789; q_check = 1'b1; q_expect = 7'h7F; settle_cycles = 4'd8;
    @(negedge clk);
    q_valid = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_aborted("abort_settle");
    // Abort during RESP, coinciding with a handshake attempt.
    q_valid = 1'b1; q_pattern = 36'h0_0F0F_0F0F; q_check = 1'b1; q_expect = 7'h7F; settle_cycles = 4'd0;
    @(negedge clk);
    q_valid = 1'b0;
    @(negedge clk);
    chk("pre_abort_valid", 64'(r_valid), 64'(1));
    abort = 1'b1; r_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; r_ready = 1'b0;
    chk_aborted("abort_resp");
    // Abort coinciding with an accept after a normal completion.
    query(36'h3_3333_3333, 7'h00, 1'b0, 4'd1, 0);
    q_valid = 1'b1; q_pattern = 36'h4_4444_4444; abort = 1'b1;
    @(negedge clk);
    q_valid = 1'b0; abort = 1'b0;
    chk_aborted("abort_accept");
    // q_valid held through the handshake: accept only on the following edge.
    q_valid = 1'b1; q_pattern = 36'h5_5555_5555; q_check = 1'b0; settle_cycles = 4'd0;
    @(negedge clk);
    @(negedge clk);
    chk("ovl_valid", 64'(r_valid), 64'(1));
    q_pattern = 36'h6_6666_6666; r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    bump(1'b0);
    chk("ovl_no_accept", 64'(busy), 64'(0));
    chk("ovl_core_in_old", 64'(core_in), 64'(36'h5_5555_5555));
    chk("ovl_qcount", 64'(query_count), 64'(mq));
    @(negedge clk);
    q_valid = 1'b0;
    chk("ovl_accept", 64'(busy), 64'(1));
    chk("ovl_core_in_new", 64'(core_in), 64'(36'h6_6666_6666));
    wait_resp(0);
    chk("ovl_response", 64'(r_response), 64'(resp_of(36'h6_6666_6666)));
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    bump(1'b0);
    chk("ovl_qcount2", 64'(query_count), 64'(mq));
    // Reset in the middle of a query discards it.
    q_valid = 1'b1; q_pattern = 36'h7_7777_7777; settle_cycles = 4'd10;
    @(negedge clk);
    q_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    mq = 0; mm = 0;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_ready", 64'(q_ready), 64'(0));
    chk("mid_rst_core_in", 64'(core_in), 64'(0));
    chk("mid_rst_qcount", 64'(query_count), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (r_valid) seen++;
    end
    chk("mid_rst_no_resp", 64'(seen), 64'(0));
    chk("mid_rst_ready_after", 64'(q_ready), 64'(1));
    // Drive both counters into saturation with fast mismatching queries.
    for (int n = 0; n < CMAX + 2; n++) begin
      p = {$urandom, $urandom};
      query(p, ~resp_of(p), 1'b1, 4'd0, 0);
    end
    chk("sat_qcount", 64'(query_count), 64'(CMAX));
    chk("sat_mcount", 64'(mismatch_count), 64'(CMAX));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/oracle_query_seq.md
ORACLE_QUERY_SEQ -- requirements
Module: oracle_query_seq

Interface
REQ-001 SHALL have parameter IN_W, default 36, meaning width of the core input pattern.
REQ-002 SHALL have parameter OUT_W, default 7, meaning width of the core output response.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the query and mismatch counters.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 abort  input  1  synchronous abort of the query in flight.
REQ-007 q_valid  input  1  query request valid.
REQ-008 q_ready  output  1  query accept ready.
REQ-009 q_pattern  input  IN_W  input vector to apply to the core.
REQ-010 q_expect  input  OUT_W  expected core response.
REQ-011 q_check  input  1  compare the captured response against q_expect.
REQ-012 settle_cycles  input  4  extra settle cycles; sampled at query accept.
REQ-013 core_in  output  IN_W  registered drive to the combinational core inputs.
REQ-014 core_out  input  OUT_W  combinational core outputs.
REQ-015 r_valid  output  1  response valid.
REQ-016 r_ready  input  1  response consumer ready.
REQ-017 r_response  output  OUT_W  captured core response.
REQ-018 r_mismatch  output  1  set when the checked response differs from q_expect.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 query_count  output  CNT_W  number of completed response handshakes.
REQ-021 mismatch_count  output  CNT_W  number of completed handshakes with r_mismatch=1.

Function
REQ-022 SHALL implement the FSM states IDLE, SETTLE and RESP.
REQ-023 q_ready SHALL equal (state==IDLE) & ~rst; the block SHALL NOT overlap queries.
REQ-024 Accept at edge k (q_valid&q_ready) SHALL, at edge k:
- load core_in<=q_pattern;
- latch q_expect, q_check and cnt<=settle_cycles;
- move to SETTLE.
REQ-025 In SETTLE, at each edge:
- cnt!=0: decrement cnt and stay in SETTLE;
- cnt==0: capture core_out into r_response, compute r_mismatch = check & (core_out!=expect), move to RESP.
REQ-026 Response latency SHALL be exactly settle_cycles+1 edges: capture happens at edge k+1+settle_cycles, and r_valid is high from that edge.
REQ-027 In RESP:
- r_valid=1;
- r_response and r_mismatch SHALL hold stable until r_valid&r_ready;
- on that handshake edge: r_valid<=0, state<=IDLE, query_count+1, mismatch_count+1 if r_mismatch.
REQ-028 A new query SHALL NOT be accepted in the same cycle as a response handshake; the earliest accept is the cycle after.
REQ-029 Both counters SHALL saturate at all-ones with no wrap.
REQ-030 core_in SHALL change only on accept, abort or reset, and SHALL hold its value through IDLE after a normal completion.
REQ-031 abort=1 at any edge SHALL, on that edge:
- force IDLE;
- clear r_valid and r_mismatch;
- set core_in to 0;
- leave the counters unchanged.
REQ-032 abort SHALL take priority over every other transition, including accept and handshake edges.
REQ-033 settle_cycles changes after accept SHALL have no effect on the query in flight.
REQ-034 r_mismatch SHALL be 0 whenever check was 0 at accept.

Reset
REQ-035 rst=1 SHALL immediately (asynchronously) force:
- state IDLE, cnt=0;
- core_in=0, r_response=0, r_valid=0, r_mismatch=0;
- busy=0, query_count=0, mismatch_count=0.
REQ-036 q_ready SHALL be 0 while rst=1 and 1 from the first cycle after deassertion.
REQ-037 Reset asserted mid-query SHALL discard the query; no count increment and no response SHALL occur.

Verification
REQ-038 settle_cycles=0, q_pattern=36'h0_0000_0001, core model returns 7'h55, r_ready=1 -> r_valid high one edge after accept with r_response=7'h55, query_count=1.
REQ-039 settle_cycles=15, core model with a 10-cycle delay -> r_valid exactly 16 edges after accept, and the captured value equals the settled output.
REQ-040 q_check=1, q_expect=7'h00, core returns 7'h01, r_ready held low for 5 cycles -> r_response and r_mismatch=1 stay stable for all 5 cycles; after the handshake mismatch_count=1.
REQ-041 abort asserted during SETTLE, and again during RESP -> each time: IDLE next edge, core_in=0, r_valid=0, counters unchanged, q_ready=1.
REQ-042 Preload near saturation (2^CNT_W-2 handshakes via fast model), then 3 more queries -> query_count stops at 16'hFFFF; q_valid held high during a handshake cycle -> accept occurs one cycle later.
